data_mem_ctrl: RTL and testbench

- Data-side memory subsystem directly downstream of the single-cycle core's data port. Consumes data_addr / store data / data_wr and returns load data in the same cycle.
- Holds a word-addressed data RAM plus a small memory-mapped I/O block: GPIO output register, free-running cycle counter, compare timer with interrupt, and an access-error status register.

---
 rtl/data_mem_ctrl.sv | 178 +++++++++++++++++
 tb/tb_data_mem_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl
// Data-side memory subsystem for a single-cycle core. It holds a word-addressed
// data RAM and a small memory-mapped I/O block. The I/O block contains a GPIO
// output register, a free-running cycle counter, a compare timer with an
// interrupt, and a sticky access-error status register.
//
// Ports:
//   clk         system clock; all state updates on its rising edge
//   rst         asynchronous, active-high reset (RAM contents are not reset)
//   data_addr   byte address from the core
//   data_wdata  store data from the core
//   data_wr     store enable from the core
//   data_rdata  load data back to the core, combinational
//   gpio_out    GPIO register contents
//   irq         level timer interrupt (timer_flag & irq_en)
//   addr_err    sticky access-error flag (STATUS[1])
//
// MMIO map (byte offset from MMIO_BASE):
//   0x00 GPIO  RW | 0x04 CYCLE RO | 0x08 TIMER_CMP RW | 0x0C TIMER_CNT RW
//   0x10 STATUS W1C {err_flag, timer_flag} | 0x14 CTRL {irq_en, timer_en}
module data_mem_ctrl #(
  parameter int          DEPTH_LOG2 = 10,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic        data_wr,
  output logic [31:0] data_rdata,
  output logic [31:0] gpio_out,
  output logic        irq,
  output logic        addr_err
);

  localparam int          WORDS     = 1 << DEPTH_LOG2;
  // Kept one bit wider than the address so the comparison cannot overflow.
  localparam logic [32:0] RAM_BYTES = 33'(WORDS) * 33'd4;

  localparam logic [31:0] OFF_GPIO   = 32'h00;
  localparam logic [31:0] OFF_CYCLE  = 32'h04;
  localparam logic [31:0] OFF_CMP    = 32'h08;
  localparam logic [31:0] OFF_CNT    = 32'h0C;
  localparam logic [31:0] OFF_STATUS = 32'h10;
  localparam logic [31:0] OFF_CTRL   = 32'h14;

  logic [31:0] mem [WORDS];

  logic [31:0] gpio_reg;
  logic [31:0] cycle_cnt;
  logic [31:0] timer_cmp;
  logic [31:0] timer_cnt;
  logic        timer_en;
  logic        irq_en;
  logic        timer_flag;
  logic        err_flag;

  logic                  misaligned;
  logic                  in_ram;
  logic                  in_mmio;
  logic [31:0]           offset;
  logic [DEPTH_LOG2-1:0] word_idx;

  logic wr_gpio;
  logic wr_cmp;
  logic wr_cnt;
  logic wr_status;
  logic wr_ctrl;
  logic bad_store;
  logic timer_hit;

  assign word_idx = data_addr[DEPTH_LOG2+1:2];

  // Address decode. Priority order: misaligned, then RAM, then the MMIO
  // window. Any other aligned address is unmapped.
  always_comb begin
    misaligned = |data_addr[1:0];
    offset     = data_addr - MMIO_BASE;
    in_ram     = !misaligned && ({1'b0, data_addr} < RAM_BYTES);
    in_mmio    = !misaligned && !in_ram &&
                 (data_addr >= MMIO_BASE) && (offset <= OFF_CTRL);
  end

  // Store strobes. A store that hits neither RAM nor MMIO is an error and
  // has no other effect. A store to CYCLE is quietly dropped.
  always_comb begin
    wr_gpio   = data_wr && in_mmio && (offset == OFF_GPIO);
    wr_cmp    = data_wr && in_mmio && (offset == OFF_CMP);
    wr_cnt    = data_wr && in_mmio && (offset == OFF_CNT);
    wr_status = data_wr && in_mmio && (offset == OFF_STATUS);
    wr_ctrl   = data_wr && in_mmio && (offset == OFF_CTRL);
    bad_store = data_wr && !in_ram && !in_mmio;
  end

  assign timer_hit = timer_en && (timer_cnt == timer_cmp);

  // Data RAM: the read is asynchronous, so a same-cycle read of the word
  // being written returns the old contents.
  always_ff @(posedge clk) begin
    if (data_wr && in_ram) begin
      mem[word_idx] <= data_wdata;
    end
  end

  // Load path. Misaligned or unmapped loads return zero.
  always_comb begin
    data_rdata = 32'h0;
    if (in_ram) begin
      data_rdata = mem[word_idx];
    end else if (in_mmio) begin
      case (offset)
        OFF_GPIO:   data_rdata = gpio_reg;
        OFF_CYCLE:  data_rdata = cycle_cnt;
        OFF_CMP:    data_rdata = timer_cmp;
        OFF_CNT:    data_rdata = timer_cnt;
        OFF_STATUS: data_rdata = {30'h0, err_flag, timer_flag};
        OFF_CTRL:   data_rdata = {30'h0, irq_en, timer_en};
        default:    data_rdata = 32'h0;
      endcase
    end
  end

  // MMIO registers. A core write to TIMER_CNT overrides the timer's own
  // update. A hardware set of either flag wins over a W1C clear in the
  // same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gpio_reg   <= 32'h0;
      cycle_cnt  <= 32'h0;
      timer_cmp  <= 32'h0;
      timer_cnt  <= 32'h0;
      timer_en   <= 1'b0;
      irq_en     <= 1'b0;
      timer_flag <= 1'b0;
      err_flag   <= 1'b0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;

      if (wr_gpio) begin
        gpio_reg <= data_wdata;
      end

      if (wr_cmp) begin
        timer_cmp <= data_wdata;
      end

      if (wr_cnt) begin
        timer_cnt <= data_wdata;
      end else if (timer_hit) begin
        timer_cnt <= 32'h0;
      end else if (timer_en) begin
        timer_cnt <= timer_cnt + 32'd1;
      end

      if (timer_hit) begin
        timer_flag <= 1'b1;
      end else if (wr_status && data_wdata[0]) begin
        timer_flag <= 1'b0;
      end

      if (bad_store) begin
        err_flag <= 1'b1;
      end else if (wr_status && data_wdata[1]) begin
        err_flag <= 1'b0;
      end

      if (wr_ctrl) begin
        timer_en <= data_wdata[0];
        irq_en   <= data_wdata[1];
      end
    end
  end

  assign gpio_out = gpio_reg;
  assign irq      = timer_flag & irq_en;
  assign addr_err = err_flag;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl
// Self-checking bench for data_mem_ctrl with its default parameters.
// A behavioural model tracks the RAM and the register state through plain
// arithmetic per clock. Each access checks load data before the edge, and
// checks gpio_out, irq and addr_err after it. Directed steps add checks
// against fixed expected constants.
module tb_data_mem_ctrl;

  localparam logic [31:0] BASE   = 32'hFFFF_0000;
  localparam logic [31:0] A_GPIO = BASE + 32'h00;
  localparam logic [31:0] A_CYC  = BASE + 32'h04;
  localparam logic [31:0] A_CMP  = BASE + 32'h08;
  localparam logic [31:0] A_CNT  = BASE + 32'h0C;
  localparam logic [31:0] A_STAT = BASE + 32'h10;
  localparam logic [31:0] A_CTRL = BASE + 32'h14;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_wr;
  logic [31:0] data_rdata;
  logic [31:0] gpio_out;
  logic        irq;
  logic        addr_err;

  always #5 clk = ~clk;

  data_mem_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .data_addr  (data_addr),
    .data_wdata (data_wdata),
    .data_wr    (data_wr),
    .data_rdata (data_rdata),
    .gpio_out   (gpio_out),
    .irq        (irq),
    .addr_err   (addr_err)
  );

  int checks = 0;
  int passed = 0;

  logic [31:0] m_ram [1024];
  logic [31:0] m_gpio;
  logic [31:0] m_cycle;
  logic [31:0] m_cmp;
  logic [31:0] m_cnt;
  logic        m_ten;
  logic        m_ien;
  logic        m_tflag;
  logic        m_eflag;
  logic [31:0] last_rdata;

  function automatic void model_reset();
    m_gpio  = 0;
    m_cycle = 0;
    m_cmp   = 0;
    m_cnt   = 0;
    m_ten   = 0;
    m_ien   = 0;
    m_tflag = 0;
    m_eflag = 0;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    if (a[1:0] != 2'b00) return 32'h0;
    if (a < 32'd4096) return m_ram[a[11:2]];
    if (a >= BASE && off <= 32'h14) begin
      case (off)
        32'h00:  return m_gpio;
        32'h04:  return m_cycle;
        32'h08:  return m_cmp;
        32'h0C:  return m_cnt;
        32'h10:  return {30'h0, m_eflag, m_tflag};
        default: return {30'h0, m_ien, m_ten};
      endcase
    end
    return 32'h0;
  endfunction

  // Advance the model by one rising edge, given the access presented before it.
  function automatic void model_step(input logic [31:0] a, input logic [31:0] w, input logic wr);
    logic        is_ram;
    logic        is_mmio;
    logic        hit;
    logic [31:0] off;
    off     = a - BASE;
    is_ram  = (a[1:0] == 2'b00) && (a < 32'd4096);
    is_mmio = (a[1:0] == 2'b00) && !is_ram && (a >= BASE) && (off <= 32'h14);
    hit     = m_ten && (m_cnt == m_cmp);
    m_cycle = m_cycle + 1;
    if (hit) begin
      m_cnt   = 0;
      m_tflag = 1;
    end else if (m_ten) begin
      m_cnt = m_cnt + 1;
    end
    if (wr) begin
      if (is_ram) begin
        m_ram[a[11:2]] = w;
      end else if (is_mmio) begin
        case (off)
          32'h00: m_gpio = w;
          32'h08: m_cmp = w;
          32'h0C: m_cnt = w;
          32'h10: begin
            if (w[0] && !hit) m_tflag = 0;
            if (w[1]) m_eflag = 0;
          end
          32'h14: begin
            m_ten = w[0];
            m_ien = w[1];
          end
          default: ;
        endcase
      end else begin
        m_eflag = 1;
      end
    end
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) begin
      passed++;
    end else begin
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // One access cycle. Inputs change just after a rising edge. Load data is
  // sampled at the falling edge, and registered outputs one unit after the
  // next rising edge.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] w, input logic wr, input logic chk_rd);
    data_addr  = a;
    data_wdata = w;
    data_wr    = wr;
    @(negedge clk);
    last_rdata = data_rdata;
    if (chk_rd) checkOutput("rdata_model", data_rdata, model_read(a));
    @(posedge clk);
    model_step(a, w, wr);
    #1;
    checkOutput("gpio_model", gpio_out, m_gpio);
    checkOutput("irq_model", {31'h0, irq}, {31'h0, m_tflag & m_ien});
    checkOutput("addr_err_model", {31'h0, addr_err}, {31'h0, m_eflag});
  endtask

  task automatic rd(input logic [31:0] a);
    applyStimulus(a, 32'h0, 1'b0, 1'b1);
  endtask

  task automatic wrt(input logic [31:0] a, input logic [31:0] w);
    applyStimulus(a, w, 1'b1, 1'b1);
  endtask

  initial begin
    logic [31:0] c0;
    logic [31:0] a;
    logic [31:0] w;
    rst        = 1'b1;
    data_addr  = 32'h0;
    data_wdata = 32'h0;
    data_wr    = 1'b0;
    #12;
    checkOutput("reset_gpio", gpio_out, 32'h0);
    checkOutput("reset_irq", {31'h0, irq}, 32'h0);
    checkOutput("reset_addr_err", {31'h0, addr_err}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();

    for (int i = 0; i < 16; i++) applyStimulus(32'(i * 4), 32'h1000_0000 + 32'(i), 1'b1, 1'b0);

    // RAM store/load and same-cycle read-before-write
    wrt(32'h10, 32'hDEAD_BEEF);
    rd(32'h10);
    checkOutput("ram_load_10", last_rdata, 32'hDEAD_BEEF);
    wrt(32'h14, 32'h0000_1234);
    checkOutput("ram_same_cycle_old", last_rdata, 32'h1000_0005);
    rd(32'h14);
    checkOutput("ram_next_cycle_new", last_rdata, 32'h0000_1234);

    // GPIO and CYCLE
    wrt(A_GPIO, 32'hA5A5_0001);
    checkOutput("gpio_after_store", gpio_out, 32'hA5A5_0001);
    rd(A_CYC);
    c0 = last_rdata;
    repeat (4) rd(32'h0);
    rd(A_CYC);
    checkOutput("cycle_delta_5", last_rdata - c0, 32'd5);
    wrt(A_CYC, 32'h0000_FFFF);
    checkOutput("cycle_store_no_err", {31'h0, addr_err}, 32'h0);
    rd(A_CYC);

    // Timer: CMP=3, CNT=0, enable timer and irq
    wrt(A_CMP, 32'd3);
    wrt(A_CNT, 32'd0);
    wrt(A_CTRL, 32'd3);
    for (int k = 0; k < 5; k++) begin
      rd(A_CNT);
      checkOutput("timer_cnt_seq", last_rdata, (k < 4) ? 32'(k) : 32'd0);
      checkOutput("timer_irq_seq", {31'h0, irq}, (k >= 3) ? 32'd1 : 32'd0);
    end
    wrt(A_STAT, 32'h1);
    checkOutput("irq_cleared", {31'h0, irq}, 32'h0);

    // Simultaneous events: the hit edge coincides with a W1C, then a CNT store
    rd(A_CNT);
    checkOutput("cnt_before_hit", last_rdata, 32'd2);
    wrt(A_STAT, 32'h1);
    checkOutput("flag_set_beats_clear", {31'h0, irq}, 32'd1);
    repeat (3) rd(A_CNT);
    checkOutput("cnt_at_compare", last_rdata, 32'd2);
    wrt(A_CNT, 32'd7);
    rd(A_CNT);
    checkOutput("cnt_write_beats_compare", last_rdata, 32'd7);

    // Access errors
    wrt(32'h0000_0002, 32'hBAD0_BAD0);
    checkOutput("misaligned_store_err", {31'h0, addr_err}, 32'd1);
    rd(32'h0);
    checkOutput("ram_word0_untouched", last_rdata, 32'h1000_0000);
    wrt(32'h8000_0000, 32'h1);
    checkOutput("unmapped_store_err", {31'h0, addr_err}, 32'd1);
    rd(32'h8000_0000);
    checkOutput("unmapped_load_zero", last_rdata, 32'h0);
    wrt(A_STAT, 32'h2);
    checkOutput("err_w1c", {31'h0, addr_err}, 32'h0);

    // Timer wrap from all-ones
    wrt(A_STAT, 32'h1);
    wrt(A_CMP, 32'd5);
    wrt(A_CNT, 32'hFFFF_FFFF);
    rd(A_CNT);
    checkOutput("cnt_all_ones", last_rdata, 32'hFFFF_FFFF);
    checkOutput("wrap_no_flag", {31'h0, irq}, 32'h0);
    for (int k = 0; k < 6; k++) begin
      rd(A_CNT);
      checkOutput("wrap_cnt_seq", last_rdata, 32'(k));
      checkOutput("wrap_irq_seq", {31'h0, irq}, (k == 5) ? 32'd1 : 32'd0);
    end

    // Randomized traffic across every region
    repeat (300) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: a = 32'($urandom_range(0, 15)) * 4;
        4:          a = 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(1, 3));
        5, 6, 7:    a = BASE + 32'($urandom_range(0, 5)) * 4;
        8: begin
          case ($urandom_range(0, 3))
            0:       a = 32'h0000_1000;
            1:       a = BASE + 32'h18;
            2:       a = BASE - 32'h4;
            default: a = 32'h8000_0000 | ($urandom & 32'h0FFF_FFFC);
          endcase
        end
        default:    a = 32'h0;
      endcase
      if (a == A_CMP || a == A_CNT) w = 32'($urandom_range(0, 6));
      else w = $urandom;
      applyStimulus(a, w, 1'($urandom_range(0, 1)), 1'b1);
    end

    // Mid-operation reset with every output driven high first
    wrt(A_GPIO, 32'h1234_5678);
    wrt(32'h0000_0003, 32'h0);
    wrt(A_CTRL, 32'd3);
    wrt(A_CMP, 32'd0);
    wrt(A_CNT, 32'd0);
    rd(32'h0);
    checkOutput("pre_reset_irq", {31'h0, irq}, 32'd1);
    checkOutput("pre_reset_err", {31'h0, addr_err}, 32'd1);
    data_addr = A_CYC;
    #3;
    rst = 1'b1;
    #1;
    checkOutput("async_reset_gpio", gpio_out, 32'h0);
    checkOutput("async_reset_irq", {31'h0, irq}, 32'h0);
    checkOutput("async_reset_err", {31'h0, addr_err}, 32'h0);
    checkOutput("async_reset_cycle", data_rdata, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    rd(A_CYC);
    checkOutput("cycle_after_reset", last_rdata, 32'h0);
    rd(A_CTRL);
    rd(32'h0);
    checkOutput("ram_survives_reset", last_rdata, m_ram[0]);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
